// File: rtl/gemm_drain.sv
// Result drain for a GEMM systolic array: grants one matrix at a time into a FWFT buffer.
// Optional build macro GEMM_DRAIN_STATS_EN enables the delivered-matrix counter on o_mat_cnt.
module gemm_drain #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DIM        = 4,
  parameter int C_FIFO_DEPTH = 2 * C_DIM * C_DIM
) (
  input  logic                    clock,
  input  logic                    i_reset_n,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    o_rd_output,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    o_overflow,
  output logic                    o_protocol_err,
  output logic [15:0]             o_mat_cnt
);

  localparam int MAT = C_DIM * C_DIM;
  localparam int PW  = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(C_FIFO_DEPTH + 1);
  localparam int BW  = (MAT > 1) ? $clog2(MAT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, COLLECT} state_t;

  state_t                  state, state_nxt;
  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [C_FIFO_DEPTH-1:0] tag_mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic [BW-1:0]           beat;
  logic                    accept, push, pop, full, beat_last, grant_ok;
  logic [CW-1:0]           free_after_pop;

  assign out_valid      = (count != '0);
  assign pop            = out_valid && out_ready;
  assign full           = (count == CW'(C_FIFO_DEPTH));
  assign push           = accept && (!full || pop);
  assign beat_last      = (beat == BW'(MAT - 1));
  // A matrix is only granted once the whole of it is guaranteed to fit.
  assign free_after_pop = CW'(C_FIFO_DEPTH) - count + CW'(pop);
  assign grant_ok       = (free_after_pop >= CW'(MAT));
  assign out_data       = out_valid ? mem[rd_ptr] : '0;
  assign out_last       = out_valid && tag_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = GRANT;
      GRANT:   if (in_valid) state_nxt = beat_last ? IDLE : COLLECT;
      COLLECT: if (in_valid && beat_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_rd_output = (state == GRANT);
    accept      = in_valid && (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      beat           <= '0;
      o_overflow     <= 1'b0;
      o_protocol_err <= 1'b0;
    end else begin
      if (accept) beat <= beat_last ? '0 : beat + 1'b1;
      if (push) wr_ptr <= (wr_ptr == PW'(C_FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(C_FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (accept && !push) o_overflow <= 1'b1;
      if (in_valid && (state == IDLE)) o_protocol_err <= 1'b1;
    end
  end

  // Storage needs no reset: out_data/out_last are masked while the buffer is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr]     <= in_data;
      tag_mem[wr_ptr] <= beat_last;
    end
  end

`ifdef GEMM_DRAIN_STATS_EN
  logic [15:0] mat_cnt;

  always_ff @(posedge clock) begin
    if (!i_reset_n)          mat_cnt <= '0;
    else if (pop && out_last) mat_cnt <= mat_cnt + 16'd1;
  end

  assign o_mat_cnt = mat_cnt;
`else
  assign o_mat_cnt = '0;
`endif

endmodule

// File: tb/tb_gemm_drain.sv
// Directed bench for gemm_drain: one instance with a 32-entry buffer, one with exactly one matrix of space.
module tb_gemm_drain;

  logic        clock;
  logic        a_reset_n, a_in_valid, a_out_ready;
  logic [31:0] a_in_data;
  logic        a_rd_output, a_out_valid, a_out_last, a_overflow, a_protocol_err;
  logic [31:0] a_out_data;
  logic [15:0] a_mat_cnt;

  logic        b_reset_n, b_in_valid, b_out_ready;
  logic [31:0] b_in_data;
  logic        b_rd_output, b_out_valid, b_out_last, b_overflow, b_protocol_err;
  logic [31:0] b_out_data;
  logic [15:0] b_mat_cnt;

  int checkCount = 0;
  int errorCount = 0;

  gemm_drain #(.C_DATA_WIDTH(32), .C_DIM(4), .C_FIFO_DEPTH(32)) dut_a (
    .clock(clock), .i_reset_n(a_reset_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .o_rd_output(a_rd_output), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last), .o_overflow(a_overflow),
    .o_protocol_err(a_protocol_err), .o_mat_cnt(a_mat_cnt)
  );

  gemm_drain #(.C_DATA_WIDTH(32), .C_DIM(4), .C_FIFO_DEPTH(16)) dut_b (
    .clock(clock), .i_reset_n(b_reset_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .o_rd_output(b_rd_output), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .o_overflow(b_overflow),
    .o_protocol_err(b_protocol_err), .o_mat_cnt(b_mat_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one beat into instance A and checks the FWFT head one cycle later.
  task automatic applyStimulus(input logic [31:0] value, input logic expLast);
    a_in_valid = 1'b1;
    a_in_data  = value;
    tick();
    checkOutput("a_fwft_data", a_out_data, value);
    checkOutput("a_fwft_last", {31'd0, a_out_last}, {31'd0, expLast});
  endtask

  initial begin
    logic [15:0] expMat;
    a_reset_n = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_reset_n = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_rd_output", {31'd0, a_rd_output}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    checkOutput("rst_out_data", a_out_data, 32'd0);
    checkOutput("rst_out_last", {31'd0, a_out_last}, 32'd0);
    checkOutput("rst_overflow", {31'd0, a_overflow}, 32'd0);
    checkOutput("rst_protocol_err", {31'd0, a_protocol_err}, 32'd0);
    checkOutput("rst_mat_cnt", {16'd0, a_mat_cnt}, 32'd0);

    a_reset_n = 1'b1;
    tick();
    checkOutput("grant_after_release", {31'd0, a_rd_output}, 32'd1);

    // Single matrix streamed straight through with the user always ready.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(k, k == 16);
      if (k == 1) checkOutput("no_grant_in_collect", {31'd0, a_rd_output}, 32'd0);
    end
    a_in_valid = 1'b0;
    tick();
    checkOutput("empty_after_stream", {31'd0, a_out_valid}, 32'd0);
    checkOutput("regrant_after_stream", {31'd0, a_rd_output}, 32'd1);

    // Two matrices buffered with the user stalled; the third grant must wait.
    a_out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      a_in_valid = 1'b1; a_in_data = k; tick();
    end
    a_in_valid = 1'b0;
    tick();
    checkOutput("second_grant", {31'd0, a_rd_output}, 32'd1);
    checkOutput("stall_head_data", a_out_data, 32'd1);
    for (int k = 17; k <= 32; k++) begin
      a_in_valid = 1'b1; a_in_data = k; tick();
    end
    a_in_valid = 1'b0;
    tick();
    checkOutput("third_grant_withheld", {31'd0, a_rd_output}, 32'd0);
    tick();
    checkOutput("third_grant_still_withheld", {31'd0, a_rd_output}, 32'd0);
    checkOutput("stall_head_stable", a_out_data, 32'd1);
    checkOutput("stall_last_stable", {31'd0, a_out_last}, 32'd0);
    a_out_ready = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      checkOutput("drain_data", a_out_data, k);
      checkOutput("drain_last", {31'd0, a_out_last}, {31'd0, (k == 16) || (k == 32)});
      tick();
    end
    checkOutput("drain_empty", {31'd0, a_out_valid}, 32'd0);
`ifdef GEMM_DRAIN_STATS_EN
    expMat = 16'd3;
`else
    expMat = 16'd0;
`endif
    checkOutput("mat_cnt_three", {16'd0, a_mat_cnt}, {16'd0, expMat});
    checkOutput("a_no_overflow", {31'd0, a_overflow}, 32'd0);
    checkOutput("a_no_protocol_err", {31'd0, a_protocol_err}, 32'd0);

    // Reset in the middle of a matrix discards everything buffered.
    a_out_ready = 1'b0;
    for (int k = 50; k <= 56; k++) begin
      a_in_valid = 1'b1; a_in_data = k; tick();
    end
    a_in_valid = 1'b0;
    a_reset_n  = 1'b0;
    tick();
    checkOutput("midrst_out_valid", {31'd0, a_out_valid}, 32'd0);
    checkOutput("midrst_out_data", a_out_data, 32'd0);
    checkOutput("midrst_rd_output", {31'd0, a_rd_output}, 32'd0);
    checkOutput("midrst_mat_cnt", {16'd0, a_mat_cnt}, 32'd0);
    a_reset_n   = 1'b1;
    a_out_ready = 1'b1;
    tick();
    checkOutput("midrst_regrant", {31'd0, a_rd_output}, 32'd1);
    for (int k = 201; k <= 216; k++) applyStimulus(k, k == 216);
    a_in_valid = 1'b0;
    tick();
    checkOutput("midrst_drained", {31'd0, a_out_valid}, 32'd0);

    // Instance B: data arriving while idle is rejected.
    b_reset_n  = 1'b1;
    b_in_valid = 1'b1;
    b_in_data  = 32'hAA;
    tick();
    b_in_valid = 1'b0;
    checkOutput("idle_push_protocol_err", {31'd0, b_protocol_err}, 32'd1);
    checkOutput("idle_push_no_write", {31'd0, b_out_valid}, 32'd0);
    checkOutput("idle_push_grant", {31'd0, b_rd_output}, 32'd1);

    // Fill B completely, then push one extra word.
    for (int k = 101; k <= 116; k++) begin
      b_in_valid = 1'b1; b_in_data = k; tick();
    end
    b_in_valid = 1'b0;
    tick();
    checkOutput("full_no_grant", {31'd0, b_rd_output}, 32'd0);
    // A grant cannot be reached legally while full; force one to exercise the drop path.
    force dut_b.grant_ok = 1'b1;
    tick();
    release dut_b.grant_ok;
    checkOutput("forced_grant", {31'd0, b_rd_output}, 32'd1);
    b_in_valid = 1'b1; b_in_data = 32'd117;
    tick();
    b_in_valid = 1'b0;
    checkOutput("overflow_set", {31'd0, b_overflow}, 32'd1);
    checkOutput("overflow_head", b_out_data, 32'd101);
    tick();
    checkOutput("overflow_sticky", {31'd0, b_overflow}, 32'd1);
    b_out_ready = 1'b1;
    for (int k = 101; k <= 116; k++) begin
      checkOutput("b_drain_data", b_out_data, k);
      checkOutput("b_drain_last", {31'd0, b_out_last}, {31'd0, k == 116});
      tick();
    end
    checkOutput("b_dropped_word_absent", {31'd0, b_out_valid}, 32'd0);
    checkOutput("overflow_held", {31'd0, b_overflow}, 32'd1);
    b_reset_n = 1'b0;
    tick();
    checkOutput("overflow_cleared", {31'd0, b_overflow}, 32'd0);
    checkOutput("protocol_err_cleared", {31'd0, b_protocol_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
